mult_dispatch: RTL and testbench

//  Upstream operand dispatcher for the 8x8 sequential shift-add multiplier (mult).
//  - Buffers operand pairs in a small FIFO and issues one start pulse per pair.
//  - Detects completion and holds each 16-bit product on a valid/ready output port until it is taken.
//  - Sits between the operand producer and mult; decouples producer timing from the 8-cycle multiply.

---
 rtl/mult_pkg.sv | 19 +
 rtl/op_fifo.sv | 43 ++++
 rtl/mult_dispatch.sv | 113 +++++++++++
 tb/tb_mult_dispatch.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, operand-pair type, FSM state encoding and retry limit for mult_dispatch
//   OPW       operand width
//   PW        product width
//   ACCW      accumulator width (used only when MULT_DISPATCH_ACC_EN is defined)
//   RETRY_LIM idle cycles in WAIT_HI before mul_start is pulsed again
package mult_pkg;
    localparam int OPW = 8;
    localparam int PW = 16;
    localparam int ACCW = 24;
    localparam int RETRY_LIM = 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;
    typedef struct packed {
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } op_t;
endpackage

// File: rtl/op_fifo.sv
// op_fifo: circular operand FIFO with occupancy count; push is ignored when full, pop when empty
//   clk, rst   clock, asynchronous active-low reset
//   push, din  write request and data
//   pop, dout  read request and head-of-queue data
//   ready      high while cnt < DEPTH
//   cnt        current occupancy (AW+1 bits)
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int AW = 2,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         ready,
    output logic [AW:0]  cnt
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign ready = cnt != (AW+1)'(DEPTH);
    assign do_push = push && ready;
    assign do_pop = pop && cnt != '0;
    assign dout = mem[rd_ptr];
    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mult_dispatch.sv
// mult_dispatch: buffers operand pairs, issues them to the sequential multiplier and holds each product on a valid/ready port
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid, in_ready, in_a/b   operand-pair input handshake
//   mul_start, mul_a/b           start pulse and held operands to mult
//   mul_busy, mul_y              mult status and product
//   out_valid, out_ready, out_y  product output handshake
//   fifo_cnt                     operand FIFO occupancy
//   acc_clr, acc                 running product sum, present only with MULT_DISPATCH_ACC_EN defined
module mult_dispatch
    import mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_a,
    input  logic [OPW-1:0]  in_b,
    output logic            mul_start,
    output logic [OPW-1:0]  mul_a,
    output logic [OPW-1:0]  mul_b,
    input  logic            mul_busy,
    input  logic [PW-1:0]   mul_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PW-1:0]   out_y,
    output logic [AW:0]     fifo_cnt
`ifdef MULT_DISPATCH_ACC_EN
    ,
    input  logic            acc_clr,
    output logic [ACCW-1:0] acc
`endif
);
    logic [1:0] state;
    logic [1:0] wait_cnt;
    logic retried;
    logic go;
    logic capture;
    op_t head;
    // a new pair may issue in the same cycle the held product is taken
    assign go = state == S_IDLE && fifo_cnt != '0 && (!out_valid || out_ready);
    // completion is defined solely by busy falling
    assign capture = state == S_WAIT_LO && !mul_busy;
    op_fifo #(.DEPTH(DEPTH), .AW(AW), .W($bits(op_t))) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(in_valid),
        .din({in_a, in_b}),
        .pop(go),
        .dout(head),
        .ready(in_ready),
        .cnt(fifo_cnt)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            mul_start <= 1'b0;
            mul_a <= '0;
            mul_b <= '0;
            out_valid <= 1'b0;
            out_y <= '0;
            wait_cnt <= '0;
            retried <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // operands are registered here so they are valid for the whole ISSUE cycle
                    if (go) begin
                        mul_a <= head.a;
                        mul_b <= head.b;
                        mul_start <= 1'b1;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    retried <= 1'b0;
                    state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    // a start that mult never acknowledged gets exactly one more pulse
                    if (mul_busy) state <= S_WAIT_LO;
                    else if (wait_cnt == 2'(RETRY_LIM - 1)) begin
                        if (!retried) begin
                            mul_start <= 1'b1;
                            retried <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end else wait_cnt <= wait_cnt + 2'd1;
                end
                default: begin
                    if (capture) begin
                        out_y <= mul_y;
                        out_valid <= 1'b1;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
`ifdef MULT_DISPATCH_ACC_EN
    // a clear coinciding with a capture restarts the sum from that product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc <= '0;
        else if (capture) acc <= (acc_clr ? '0 : acc) + ACCW'(mul_y);
        else if (acc_clr) acc <= '0;
    end
`endif
endmodule

// File: tb/tb_mult_dispatch.sv
// tb_mult_dispatch: self-checking bench with a behavioural 8-cycle multiplier and a product scoreboard
module tb_mult_dispatch;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid, in_ready, mul_start, mul_busy, out_valid, out_ready;
    logic [7:0] in_a, in_b, mul_a, mul_b;
    logic [15:0] mul_y, out_y;
    logic [2:0] fifo_cnt;
`ifdef MULT_DISPATCH_ACC_EN
    logic acc_clr;
    logic [23:0] acc;
`endif
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int mcnt = 0;
    int pend = 0;
    int pend_n = 0;
    int starts = 0;
    int drop_req = 0;
    int drop_done = 0;
    bit inflight = 0;
    bit hold = 0;
    logic [15:0] hold_y = '0;
    logic [3:0] mk;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    always #5 clk = ~clk;

    mult_dispatch #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy), .mul_y(mul_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .fifo_cnt(fifo_cnt)
`ifdef MULT_DISPATCH_ACC_EN
        , .acc_clr(acc_clr), .acc(acc)
`endif
    );

    // behavioural mult (busy for 8 cycles after an accepted start, product on busy fall)
    // plus the reference model: accepted pairs become expected products in push order
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            mcnt = 0;
            inflight = 0;
            mul_busy <= 1'b0;
            mul_y <= '0;
            mk <= '0;
        end else begin
            cyc++;
            pend = (mul_start && !inflight) ? 1 : 0;
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && mcnt - pend < DEPTH) begin
                exp_q.push_back(16'(in_a) * 16'(in_b));
                mcnt++;
            end
            if (mul_start) starts++;
            if (pend == 1) begin
                mcnt--;
                inflight = 1;
            end
            if (mul_busy) begin
                if (mk == 0) begin
                    mul_busy <= 1'b0;
                    mul_y <= 16'(mul_a) * 16'(mul_b);
                    inflight = 0;
                end else mk <= mk - 4'd1;
            end else if (mul_start) begin
                if (drop_req != drop_done) drop_done++;
                else begin
                    mul_busy <= 1'b1;
                    mk <= 4'd7;
                    mul_y <= 16'hDEAD;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst) hold = 0;
            else begin
                pend_n = (mul_start && !inflight) ? 1 : 0;
                chk("fifo_cnt", 32'(fifo_cnt), 32'(mcnt - pend_n));
                chk("in_ready", 32'(in_ready), 32'(mcnt - pend_n < DEPTH));
                if (hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_y", 32'(out_y), 32'(hold_y));
                end
                hold = out_valid && !out_ready;
                hold_y = out_y;
                if (out_valid && out_ready) begin
                    chk("out_y", 32'(out_y), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
                    got_q.push_back(out_y);
                end
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < 500 && !in_ready; k++) sync();
        chk("push_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        sync();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && mcnt == 0 && !inflight && !out_valid) begin
                done = 1;
                break;
            end
            sync();
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, s0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
`ifdef MULT_DISPATCH_ACC_EN
        acc_clr = 1'b0;
`endif
        fork
            compare_loop();
        join_none
        repeat (3) sync();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
`ifdef MULT_DISPATCH_ACC_EN
        chk("rst_acc", 32'(acc), 32'd0);
`endif
        rst = 1'b1;
        sync();

        // single op: start-to-valid latency and literal product
        s0 = starts;
        push(8'd13, 8'd11);
        t0 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mul_start) begin
                t0 = cyc;
                break;
            end
        end
        chk("single_start_seen", 32'(t0 >= 0), 32'd1);
        t1 = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) begin
                t1 = cyc;
                break;
            end
        end
        chk("start_to_valid", 32'(t1 - t0), 32'd10);
        chk("single_y", 32'(out_y), 32'd143);
        chk("single_starts", 32'(starts - s0), 32'd1);
        sync();
        out_ready = 1'b1;
        drain(50);

        // extremes in push order
        got_q.delete();
        push(8'd255, 8'd255);
        push(8'd0, 8'd200);
        drain(300);
        chk("ext_count", 32'(got_q.size()), 32'd2);
        chk("ext_y0", got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h0000_FE01);
        chk("ext_y1", got_q.size() > 1 ? 32'(got_q[1]) : 32'hFFFF_FFFF, 32'h0000_0000);

        // full FIFO with the first product held
        out_ready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = 8'(20 + i);
            in_b = 8'(3 + i);
            sync();
        end
        in_valid = 1'b0;
        repeat (30) sync();
        chk("full_cnt", 32'(fifo_cnt), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_y", 32'(out_y), 32'd60);
        chk("full_accepted", 32'(exp_q.size()), 32'd5);
        out_ready = 1'b1;
        drain(400);
        chk("full_count", 32'(got_q.size()), 32'd5);
        chk("full_last", got_q.size() > 4 ? 32'(got_q[4]) : 32'hFFFF_FFFF, 32'd168);

        // simultaneous push and pop at fifo_cnt=2
        out_ready = 1'b0;
        got_q.delete();
        push(8'd2, 8'd2);
        push(8'd3, 8'd3);
        push(8'd4, 8'd4);
        for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        chk("pp_valid", 32'(out_valid), 32'd1);
        sync();
        chk("pp_cnt_before", 32'(fifo_cnt), 32'd2);
        in_valid = 1'b1;
        in_a = 8'd5;
        in_b = 8'd5;
        out_ready = 1'b1;
        sync();
        in_valid = 1'b0;
        chk("pp_cnt_after", 32'(fifo_cnt), 32'd2);
        chk("pp_start", 32'(mul_start), 32'd1);
        drain(300);
        chk("pp_count", 32'(got_q.size()), 32'd4);
        chk("pp_last", got_q.size() > 3 ? 32'(got_q[3]) : 32'hFFFF_FFFF, 32'd25);

        // pointer wrap: 10 sequential pairs
        got_q.delete();
        for (int i = 1; i <= 10; i++) push(8'(i), 8'(i + 1));
        drain(600);
        chk("wrap_count", 32'(got_q.size()), 32'd10);
        for (int i = 1; i <= 10; i++)
            chk("wrap_y", i <= got_q.size() ? 32'(got_q[i-1]) : 32'hFFFF_FFFF, 32'(i * (i + 1)));

        // lost start: mult ignores the first pulse, the dispatcher retries once
        got_q.delete();
        drop_req++;
        s0 = starts;
        push(8'd7, 8'd9);
        drain(100);
        chk("retry_starts", 32'(starts - s0), 32'd2);
        chk("retry_y", got_q.size() > 0 ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'd63);

        // randomized traffic with random backpressure
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            sync();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(2000);

`ifdef MULT_DISPATCH_ACC_EN
        acc_clr = 1'b1;
        sync();
        acc_clr = 1'b0;
        chk("acc_clr", 32'(acc), 32'd0);
        push(8'd2, 8'd3);
        push(8'd4, 8'd5);
        drain(300);
        chk("acc_sum", 32'(acc), 32'd26);
        acc_clr = 1'b1;
        sync();
        acc_clr = 1'b0;
        push(8'd1, 8'd1);
        drain(100);
        chk("acc_after_clr", 32'(acc), 32'd1);
`endif

        // asynchronous reset while a multiply is in flight
        push(8'd3, 8'd3);
        push(8'd5, 8'd5);
        push(8'd6, 8'd6);
        for (int k = 0; k < 40 && !mul_busy; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("mid_busy", 32'(mul_busy), 32'd1);
        chk("mid_cnt", 32'(fifo_cnt), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt", 32'(fifo_cnt), 32'd0);
        chk("arst_start", 32'(mul_start), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        sync();
        rst = 1'b1;
        got_q.delete();
        repeat (30) sync();
        chk("post_rst_none", 32'(got_q.size()), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_cnt", 32'(fifo_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
